vga_timing_recovery: RTL

Sink-side counterpart of the 640x480 display timing generator. It takes a raw hsync/vsync/de stream and recovers pixel coordinates (sx, sy) aligned to active video. It also measures line/frame geometry, compares it against expected 640x480 values, and asserts `locked` after consecutive matching frames. It sits between a capture/loopback input and downstream pixel consumers (frame checker, scaler, test pattern comparator).

---
 rtl/vga_timing_recovery.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_recovery.sv
// ============================================================================
// Module   : vga_timing_recovery
// Purpose  : Recovers sx/sy from a raw hsync/vsync/de stream, measures line and
//            frame geometry and asserts locked after consecutive good frames.
//            Optional macro VGA_RX_ERR_CNT_EN adds the saturating err_count port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_recovery #(
    parameter int HA_EXP      = 640,
    parameter int VA_EXP      = 480,
    parameter int LINE_EXP    = 800,
    parameter int SCREEN_EXP  = 525,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 12
) (
    input  logic          clk_pix,
    input  logic          rst,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          de_in,
    output logic          de_out,
    output logic [9:0]    sx,
    output logic [9:0]    sy,
    output logic          frame_start,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_active,
    output logic          locked,
    output logic          err
`ifdef VGA_RX_ERR_CNT_EN
    ,
    output logic [7:0]    err_count
`endif
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_MAX    = '1;
    localparam logic [CW-1:0] C_LINE   = CW'(LINE_EXP);
    localparam logic [CW-1:0] C_LIMIT  = CW'(2 * LINE_EXP);
    localparam logic [CW-1:0] C_HA     = CW'(HA_EXP);
    localparam logic [CW-1:0] C_VA     = CW'(VA_EXP);
    localparam logic [CW-1:0] C_SCREEN = CW'(SCREEN_EXP);
    localparam logic [3:0]    C_LOCK   = 4'(LOCK_FRAMES);

    logic          hs_q, vs_q, de_q;
    logic          de_out_q, fs_q, v_pend_q;
    logic [9:0]    sx_q, sy_q;
    logic [CW-1:0] line_cnt_q, run_cnt_q, hcnt_q, dcnt_q;
    logic [CW-1:0] h_total_q, h_active_q, v_total_q, v_active_q;
    logic          h_seen_q, line_bad_q;
    state_t        state_q, state_d;
    logic [3:0]    match_q, match_d;
    logic          locked_q, locked_d, err_q, err_d;

    logic          hs_edge, vs_edge, de_rise, de_fall;
    logic [CW-1:0] line_inc, run_inc, v_total_nx, v_active_nx;
    logic          line_bad_now, frame_ok, timeout;

    assign hs_edge = !hsync_in && hs_q;
    assign vs_edge = !vsync_in && vs_q;
    assign de_rise = de_in && !de_q;
    assign de_fall = !de_in && de_q;

    assign line_inc = (line_cnt_q == C_MAX) ? C_MAX : line_cnt_q + 1'b1;
    assign run_inc  = (run_cnt_q == C_MAX) ? C_MAX : run_cnt_q + 1'b1;

    // An hsync edge coincident with vsync still belongs to the ending frame.
    assign v_total_nx  = hcnt_q + {{(CW-1){1'b0}}, hs_edge};
    assign v_active_nx = dcnt_q + {{(CW-1){1'b0}}, de_rise};

    assign line_bad_now = line_bad_q
                        || (hs_edge && h_seen_q && (line_inc != C_LINE))
                        || (de_fall && (run_cnt_q != C_HA));
    assign frame_ok = !line_bad_now && (v_total_nx == C_SCREEN) && (v_active_nx == C_VA);
    assign timeout  = (state_q != SEARCH) && (line_cnt_q >= C_LIMIT);

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        if (timeout) begin
            state_d  = SEARCH;
            match_d  = 4'd0;
            locked_d = 1'b0;
            err_d    = (state_q == LOCKED);
        end else if (vs_edge) begin
            case (state_q)
                SEARCH: begin
                    state_d = MEASURE;
                    match_d = 4'd0;
                end
                MEASURE: begin
                    if (frame_ok) begin
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 == C_LOCK) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!frame_ok) begin
                        state_d  = SEARCH;
                        match_d  = 4'd0;
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_q  <= SEARCH;
            match_q  <= 4'd0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
            de_out_q   <= 1'b0;
            fs_q       <= 1'b0;
            v_pend_q   <= 1'b0;
            sx_q       <= '0;
            sy_q       <= '0;
            line_cnt_q <= '0;
            run_cnt_q  <= '0;
            hcnt_q     <= '0;
            dcnt_q     <= '0;
            h_total_q  <= '0;
            h_active_q <= '0;
            v_total_q  <= '0;
            v_active_q <= '0;
            h_seen_q   <= 1'b0;
            line_bad_q <= 1'b0;
        end else begin
            hs_q     <= hsync_in;
            vs_q     <= vsync_in;
            de_q     <= de_in;
            de_out_q <= de_in;
            fs_q     <= de_rise && v_pend_q;

            if (de_rise) begin
                sx_q <= '0;
            end else if (de_in) begin
                sx_q <= sx_q + 10'd1;
            end

            if (de_rise) begin
                sy_q <= v_pend_q ? 10'd0 : sy_q + 10'd1;
            end
            if (vs_edge) begin
                v_pend_q <= 1'b1;
            end else if (de_rise) begin
                v_pend_q <= 1'b0;
            end

            if (hs_edge) begin
                line_cnt_q <= '0;
                h_seen_q   <= 1'b1;
                if (h_seen_q) begin
                    h_total_q <= line_inc;
                end
            end else begin
                line_cnt_q <= line_inc;
            end
            // A missing hsync invalidates the partial line in flight.
            if (timeout) begin
                h_seen_q <= 1'b0;
            end

            if (de_in) begin
                run_cnt_q <= de_rise ? {{(CW-1){1'b0}}, 1'b1} : run_inc;
            end else if (de_fall) begin
                h_active_q <= run_cnt_q;
                run_cnt_q  <= '0;
            end

            if (vs_edge) begin
                v_total_q  <= v_total_nx;
                v_active_q <= v_active_nx;
                hcnt_q     <= '0;
                dcnt_q     <= '0;
                line_bad_q <= 1'b0;
            end else begin
                hcnt_q     <= v_total_nx;
                dcnt_q     <= v_active_nx;
                line_bad_q <= line_bad_now;
            end
        end
    end

`ifdef VGA_RX_ERR_CNT_EN
    logic [7:0] err_count_q;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            err_count_q <= 8'd0;
        end else if (err_q && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`endif

    assign de_out      = de_out_q;
    assign sx          = sx_q;
    assign sy          = sy_q;
    assign frame_start = fs_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign h_active    = h_active_q;
    assign v_active    = v_active_q;
    assign locked      = locked_q;
    assign err         = err_q;

endmodule

`default_nettype wire
